// File: rtl/borrow_look_ahead_sub_16bit_pipe_if.sv
// Operand/result bundle for the pipelined 16-bit borrow-lookahead subtractor.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : subtractor side (drives in_ready and the result)
// Signals:
//   a, b, bin, in_valid -> operand set offered to the subtractor
//   in_ready            <- subtractor can take an operand set this cycle
//   diff, bout, ovf     <- a - b - bin, borrow out, signed overflow
//   out_valid           <- result valid
//   out_ready           -> downstream takes the result this cycle
interface borrow_look_ahead_sub_16bit_pipe_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, bin, in_valid, out_ready,
        input  in_ready, diff, bout, ovf, out_valid
    );

    modport slave (
        input  a, b, bin, in_valid, out_ready,
        output in_ready, diff, bout, ovf, out_valid
    );
endinterface

// File: rtl/borrow_look_ahead_sub_16bit_pipe.sv
// Four-stage pipelined 16-bit subtractor, diff = a - b - bin (mod 2^16).
// Each stage resolves one 4-bit slice with borrow lookahead and hands its
// borrow to the next slice; the not-yet-used upper operand bits ride along.
// The whole pipe advances together when the output register is empty or
// being drained, so in_ready is simply that advance condition.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears everything
//   bus  : operand/result handshake (slave modport)
module borrow_look_ahead_sub_16bit_pipe (
    input  logic clk,
    input  logic rst,
    borrow_look_ahead_sub_16bit_pipe_if.slave bus
);

    localparam int DATA_W = 16;

    // 4-bit borrow lookahead: returns {borrow_out, diff[3:0]}.
    // g = ~a & b (slice bit makes a borrow), p = ~(a ^ b) (bit passes it on).
    function automatic logic [4:0] bla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       bi
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = ~x & y;
        p    = ~(x ^ y);
        c[0] = bi;
        c[1] = g[0] | (p[0] & bi);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & bi);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & bi);
        return {c[4], x ^ y ^ c[3:0]};
    endfunction

    // Signed overflow: operands of different sign and result sign differs from a.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

    logic                 adv;

    logic                 vld_p0;
    logic [DATA_W-1:0]    a_p0;
    logic [DATA_W-1:0]    b_p0;
    logic                 brw_p0;

    logic                 vld_p1;
    logic [DATA_W-1:4]    a_p1;
    logic [DATA_W-1:4]    b_p1;
    logic [3:0]           d_p1;
    logic                 brw_p1;

    logic                 vld_p2;
    logic [DATA_W-1:8]    a_p2;
    logic [DATA_W-1:8]    b_p2;
    logic [7:0]           d_p2;
    logic                 brw_p2;

    logic                 vld_p3;
    logic [DATA_W-1:12]   a_p3;
    logic [DATA_W-1:12]   b_p3;
    logic [11:0]          d_p3;
    logic                 brw_p3;

    logic                 out_valid_r;
    logic [DATA_W-1:0]    diff_r;
    logic                 bout_r;
    logic                 ovf_r;

    logic [4:0]           s0;
    logic [4:0]           s1;
    logic [4:0]           s2;
    logic [4:0]           s3;

    assign adv = ~out_valid_r | bus.out_ready;

    assign s0 = bla4(a_p0[3:0],   b_p0[3:0],   brw_p0);
    assign s1 = bla4(a_p1[7:4],   b_p1[7:4],   brw_p1);
    assign s2 = bla4(a_p2[11:8],  b_p2[11:8],  brw_p2);
    assign s3 = bla4(a_p3[15:12], b_p3[15:12], brw_p3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            a_p0        <= '0;
            b_p0        <= '0;
            brw_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            a_p1        <= '0;
            b_p1        <= '0;
            d_p1        <= '0;
            brw_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            a_p2        <= '0;
            b_p2        <= '0;
            d_p2        <= '0;
            brw_p2      <= 1'b0;
            vld_p3      <= 1'b0;
            a_p3        <= '0;
            b_p3        <= '0;
            d_p3        <= '0;
            brw_p3      <= 1'b0;
            out_valid_r <= 1'b0;
            diff_r      <= '0;
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (adv) begin
            // capture -> p0: raw operands, bin becomes the slice-0 borrow
            vld_p0 <= bus.in_valid;
            a_p0   <= bus.a;
            b_p0   <= bus.b;
            brw_p0 <= bus.bin;

            // p0 -> p1: bits [3:0] resolved
            vld_p1 <= vld_p0;
            a_p1   <= a_p0[15:4];
            b_p1   <= b_p0[15:4];
            d_p1   <= s0[3:0];
            brw_p1 <= s0[4];

            // p1 -> p2: bits [7:4] resolved
            vld_p2 <= vld_p1;
            a_p2   <= a_p1[15:8];
            b_p2   <= b_p1[15:8];
            d_p2   <= {s1[3:0], d_p1};
            brw_p2 <= s1[4];

            // p2 -> p3: bits [11:8] resolved
            vld_p3 <= vld_p2;
            a_p3   <= a_p2[15:12];
            b_p3   <= b_p2[15:12];
            d_p3   <= {s2[3:0], d_p2};
            brw_p3 <= s2[4];

            // p3 -> output: bits [15:12] resolved; result only updates on a
            // real operand so it holds its last value across bubbles
            out_valid_r <= vld_p3;
            if (vld_p3) begin
                diff_r <= {s3[3:0], d_p3};
                bout_r <= s3[4];
                ovf_r  <= ovf_f(a_p3[15], b_p3[15], s3[3]);
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;

endmodule
